// File: rtl/cl_sim_pkg.sv
// Shared constants, types and helpers for the Camera Link 80-bit source model.
package cl_sim_pkg;

  localparam int unsigned PIXEL_SIZE    = 12;
  localparam int unsigned CL_WORD       = 40;
  localparam int unsigned PIX_PER_GROUP = 10;
  localparam int unsigned GROUP_BITS    = PIXEL_SIZE * PIX_PER_GROUP;

  typedef enum logic [1:0] {VBLANK, FRONT, LINE, HBLANK} seq_state_e;

  typedef logic [PIXEL_SIZE-1:0] pixel_t;

  // 40-bit words per line for one half-sensor stream.
  function automatic int unsigned wpl(input int unsigned n_col);
    return n_col * PIXEL_SIZE / CL_WORD;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cl_sim_if.sv
// Camera Link full-mode output bundle: framing plus ten 8-bit data ports.
interface cl_sim_if;

  logic       cl_fval;
  logic       cl_z_lval;
  logic [7:0] cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
  logic [7:0] cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;

  modport master (
    output cl_fval, cl_z_lval,
    output cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
    output cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
  );

  modport slave (
    input cl_fval, cl_z_lval,
    input cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
    input cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
  );

endinterface

// File: rtl/cl_pixel_pack.sv
// Packs a group of ten 12-bit pixels into a 120-bit stream and selects one 40-bit word.
module cl_pixel_pack
  import cl_sim_pkg::*;
(
  input  pixel_t                   pix_i [PIX_PER_GROUP],
  input  logic   [1:0]             phase_i,
  output logic   [CL_WORD-1:0]     word_o
);

  logic [GROUP_BITS-1:0] stream;

  always_comb begin
    stream = '0;
    // Pixel 0 occupies the top bits of the stream.
    for (int i = 0; i < PIX_PER_GROUP; i++) begin
      stream[GROUP_BITS-1-PIXEL_SIZE*i -: PIXEL_SIZE] = pix_i[i];
    end
    case (phase_i)
      2'd0:    word_o = stream[119:80];
      2'd1:    word_o = stream[79:40];
      2'd2:    word_o = stream[39:0];
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/cl_sim.sv
// Camera Link 80-bit source model: frame/line sequencer, pixel generator, registered outputs.
module cl_sim
  import cl_sim_pkg::*;
#(
  parameter int unsigned N_COL   = 2560,
  parameter int unsigned N_ROW   = 1080,
  parameter int unsigned H_BLANK = 64,
  parameter int unsigned V_BLANK = 1000
) (
  input  logic      clk_85,
  input  logic      reset,
  cl_sim_if.master  cl
);

  localparam int unsigned WPL    = wpl(N_COL);
  localparam int unsigned NGRP   = N_COL / PIX_PER_GROUP;
  localparam int unsigned WordW  = cnt_width(WPL);
  localparam int unsigned RowW   = cnt_width(N_ROW);
  localparam int unsigned GrpW   = cnt_width(NGRP);
  localparam int unsigned CntW   = cnt_width((V_BLANK > H_BLANK) ? V_BLANK : H_BLANK);

  seq_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WordW-1:0]       word_q, word_d;
  logic [1:0]             phase_q, phase_d;
  logic [GrpW-1:0]        grp_q, grp_d;
  logic [RowW-1:0]        row_q, row_d;
  pixel_t                 frame_q, frame_d;

  logic                   fval_q, lval_q;
  logic [CL_WORD-1:0]     top_q, bot_q;

  pixel_t                 base;
  pixel_t                 top_pix [PIX_PER_GROUP];
  pixel_t                 bot_pix [PIX_PER_GROUP];
  logic [CL_WORD-1:0]     top_word, bot_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    phase_d = phase_q;
    grp_d   = grp_q;
    row_d   = row_q;
    frame_d = frame_q;
    unique case (state_q)
      VBLANK: begin
        if (cnt_q == CntW'(V_BLANK - 1)) begin
          state_d = FRONT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRONT: begin
        if (cnt_q == CntW'(H_BLANK - 1)) begin
          state_d = LINE;
          cnt_d   = '0;
          word_d  = '0;
          phase_d = '0;
          grp_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LINE: begin
        if (word_q == WordW'(WPL - 1)) begin
          state_d = HBLANK;
        end else begin
          word_d = word_q + 1'b1;
          if (phase_q == 2'd2) begin
            phase_d = '0;
            grp_d   = grp_q + 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      HBLANK: begin
        if (cnt_q == CntW'(H_BLANK - 1)) begin
          cnt_d   = '0;
          word_d  = '0;
          phase_d = '0;
          grp_d   = '0;
          if (row_q == RowW'(N_ROW - 1)) begin
            state_d = VBLANK;
            row_d   = '0;
            frame_d = frame_q + 1'b1;
          end else begin
            state_d = LINE;
            row_d   = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = VBLANK;
    endcase
  end

  // Pixels follow the next-state counters so data lands on the same edge as lval.
  always_comb begin
    base = frame_d + PIXEL_SIZE'(row_d) + PIXEL_SIZE'(grp_d * PIX_PER_GROUP);
    for (int i = 0; i < PIX_PER_GROUP; i++) begin
      top_pix[i] = base + PIXEL_SIZE'(i);
      bot_pix[i] = top_pix[i] + 12'h800;
    end
  end

  cl_pixel_pack u_pack_top (
    .pix_i   (top_pix),
    .phase_i (phase_d),
    .word_o  (top_word)
  );

  cl_pixel_pack u_pack_bot (
    .pix_i   (bot_pix),
    .phase_i (phase_d),
    .word_o  (bot_word)
  );

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      state_q <= VBLANK;
      cnt_q   <= '0;
      word_q  <= '0;
      phase_q <= '0;
      grp_q   <= '0;
      row_q   <= '0;
      frame_q <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      phase_q <= phase_d;
      grp_q   <= grp_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      fval_q  <= (state_d != VBLANK);
      lval_q  <= (state_d == LINE);
      top_q   <= (state_d == LINE) ? top_word : '0;
      bot_q   <= (state_d == LINE) ? bot_word : '0;
    end
  end

  assign cl.cl_fval   = fval_q;
  assign cl.cl_z_lval = lval_q;
  assign {cl.cl_port_a, cl.cl_port_b, cl.cl_port_c, cl.cl_port_d, cl.cl_port_e} = top_q;
  assign {cl.cl_port_f, cl.cl_port_g, cl.cl_port_h, cl.cl_port_i, cl.cl_port_j} = bot_q;

endmodule

// File: tb/tb_cl_sim.sv
// Directed bench for cl_sim with a small geometry: 20 columns, 3 rows, short blanking.
module tb_cl_sim;

  logic clk_85 = 1'b0;
  logic reset  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  cl_sim_if bus ();

  cl_sim #(
    .N_COL   (20),
    .N_ROW   (3),
    .H_BLANK (4),
    .V_BLANK (10)
  ) dut (
    .clk_85 (clk_85),
    .reset  (reset),
    .cl     (bus)
  );

  always #5 clk_85 = ~clk_85;

  function automatic logic [39:0] top_w();
    return {bus.cl_port_a, bus.cl_port_b, bus.cl_port_c, bus.cl_port_d, bus.cl_port_e};
  endfunction

  function automatic logic [39:0] bot_w();
    return {bus.cl_port_f, bus.cl_port_g, bus.cl_port_h, bus.cl_port_i, bus.cl_port_j};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample just after the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk_85);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fval"}, 40'(bus.cl_fval), 40'd0);
    chk({tag, " lval"}, 40'(bus.cl_z_lval), 40'd0);
    chk({tag, " top"}, top_w(), 40'd0);
    chk({tag, " bot"}, bot_w(), 40'd0);
  endtask

  // Expects reset to have been released between edges; next edge is edge 1.
  task automatic startup(input string tag);
    adv(9);
    chk({tag, " e9 fval"}, 40'(bus.cl_fval), 40'd0);
    adv(1);
    chk({tag, " e10 fval"}, 40'(bus.cl_fval), 40'd1);
    chk({tag, " e10 lval"}, 40'(bus.cl_z_lval), 40'd0);
    adv(3);
    chk({tag, " e13 lval"}, 40'(bus.cl_z_lval), 40'd0);
    chk({tag, " e13 top"}, top_w(), 40'd0);
    adv(1);
    chk({tag, " e14 lval"}, 40'(bus.cl_z_lval), 40'd1);
    chk({tag, " w0 top"}, top_w(), 40'h00_00_01_00_20);
    chk({tag, " w0 bot"}, bot_w(), 40'h80_08_01_80_28);
    adv(1);
    chk({tag, " w1 top"}, top_w(), 40'h03_00_40_05_00);
    adv(1);
    chk({tag, " w2 top"}, top_w(), 40'h60_07_00_80_09);
    adv(1);
    chk({tag, " w3 top"}, top_w(), 40'h00_a0_0b_00_c0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    #20;
    @(negedge clk_85);
    reset = 1'b0;
    startup("boot");

    adv(2);
    chk("e19 lval", 40'(bus.cl_z_lval), 40'd1);
    chk("w5 top", top_w(), 40'h00_11_01_20_13);

    for (int e = 20; e <= 43; e++) begin
      logic exp_l;
      adv(1);
      exp_l = ((e >= 24) && (e <= 29)) || ((e >= 34) && (e <= 39));
      chk($sformatf("e%0d fval", e), 40'(bus.cl_fval), 40'd1);
      chk($sformatf("e%0d lval", e), 40'(bus.cl_z_lval), 40'(exp_l));
      if (!exp_l) begin
        chk($sformatf("e%0d top blank", e), top_w(), 40'd0);
        chk($sformatf("e%0d bot blank", e), bot_w(), 40'd0);
      end
      if (e == 24) begin
        chk("row1 w0 top", top_w(), 40'h00_10_02_00_30);
        chk("row1 w0 bot", bot_w(), 40'h80_18_02_80_38);
      end
      if (e == 34) chk("row2 w0 top", top_w(), 40'h00_20_03_00_40);
    end

    adv(1);
    chk_all_zero("e44 vblank");
    adv(9);
    chk("e53 fval", 40'(bus.cl_fval), 40'd0);
    adv(1);
    chk("e54 fval", 40'(bus.cl_fval), 40'd1);
    adv(4);
    chk("f1 e58 lval", 40'(bus.cl_z_lval), 40'd1);
    chk("f1 w0 top", top_w(), 40'h00_10_02_00_30);
    chk("f1 w0 bot", bot_w(), 40'h80_18_02_80_38);

    // Jump the frame counter to its last value so the next frame shows the wrap.
    force dut.frame_q = 12'hfff;
    adv(1);
    release dut.frame_q;
    adv(43);
    chk("wrap e102 lval", 40'(bus.cl_z_lval), 40'd1);
    chk("wrap w0 top", top_w(), 40'h00_00_01_00_20);
    chk("wrap w0 bot", bot_w(), 40'h80_08_01_80_28);

    adv(2);
    chk("pre-reset lval", 40'(bus.cl_z_lval), 40'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    adv(2);
    chk_all_zero("held reset");
    @(negedge clk_85);
    reset = 1'b0;
    startup("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
